// File: rtl/controle_bandeja.sv
`timescale 1ns/1ps
// Cork sealing station controller: conveyor, sealing actuator and
// a BCD count of the corks left in the tray, with low-stock and empty alarms.
module controle_bandeja #(
    parameter int TEMPO_VEDACAO  = 3,
    parameter int CARGA_DEZENAS  = 2,
    parameter int CARGA_UNIDADES = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_garrafa,
    input  logic       reabastecer,
    output logic       motor,
    output logic       vedar,
    output logic [3:0] unidades_bandeja,
    output logic [1:0] dezenas_bandeja,
    output logic       MC,
    output logic       BZ
);

    typedef enum logic [2:0] {
        ESPERA     = 3'd0,
        VEDANDO    = 3'd1,
        DECREMENTA = 3'd2,
        LIBERA     = 3'd3,
        VAZIO      = 3'd4
    } estado_t;

    localparam logic [3:0] TIMER_CARGA = 4'(TEMPO_VEDACAO - 1);
    localparam logic [1:0] CARGA_D     = 2'(CARGA_DEZENAS);
    localparam logic [3:0] CARGA_U     = 4'(CARGA_UNIDADES);

    estado_t    estado_q, estado_d;
    logic [3:0] timer_q, timer_d;
    logic [1:0] dez_q, dez_d;
    logic [3:0] uni_q, uni_d;
    logic       vazia;

    assign vazia = (dez_q == 2'd0) && (uni_q == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= ESPERA;
            timer_q  <= 4'd0;
            dez_q    <= CARGA_D;
            uni_q    <= CARGA_U;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
            dez_q    <= dez_d;
            uni_q    <= uni_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q;
        dez_d    = dez_q;
        uni_d    = uni_q;
        case (estado_q)
            ESPERA: begin
                // refill takes priority over a bottle arriving the same cycle
                if (reabastecer) begin
                    dez_d = CARGA_D;
                    uni_d = CARGA_U;
                end else if (sensor_garrafa && !vazia) begin
                    estado_d = VEDANDO;
                    timer_d  = TIMER_CARGA;
                end
            end
            VEDANDO: begin
                if (timer_q == 4'd0) begin
                    estado_d = DECREMENTA;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            DECREMENTA: begin
                estado_d = LIBERA;
                if (!vazia) begin
                    if (uni_q != 4'd0) begin
                        uni_d = uni_q - 4'd1;
                    end else begin
                        uni_d = 4'd9;
                        dez_d = dez_q - 2'd1;
                    end
                end
            end
            LIBERA: begin
                // wait for the sealed bottle to leave before counting again
                if (!sensor_garrafa) begin
                    estado_d = vazia ? VAZIO : ESPERA;
                end
            end
            VAZIO: begin
                if (reabastecer) begin
                    estado_d = ESPERA;
                    dez_d    = CARGA_D;
                    uni_d    = CARGA_U;
                end
            end
            default: estado_d = ESPERA;
        endcase
    end

    always_comb begin
        motor = 1'b1;
        vedar = 1'b0;
        BZ    = 1'b0;
        case (estado_q)
            VEDANDO: begin
                motor = 1'b0;
                vedar = 1'b1;
            end
            DECREMENTA: motor = 1'b0;
            VAZIO: begin
                motor = 1'b0;
                BZ    = 1'b1;
            end
            default: motor = 1'b1;
        endcase
    end

    assign unidades_bandeja = uni_q;
    assign dezenas_bandeja  = dez_q;
    assign MC               = (dez_q == 2'd0) && !vazia;

endmodule

// File: tb/tb_controle_bandeja.sv
`timescale 1ns/1ps
// Scoreboard bench for controle_bandeja: each step queues the expected
// outputs, clocks once, then pops and compares against the DUT.
module tb_controle_bandeja;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sensor_garrafa = 1'b0;
    logic       reabastecer = 1'b0;
    logic       motor, vedar, MC, BZ;
    logic [3:0] unidades_bandeja;
    logic [1:0] dezenas_bandeja;

    int total = 0;
    int bad = 0;
    int n = 29;

    typedef struct {
        string tag;
        logic  motor;
        logic  vedar;
        logic  bz;
        int    n;
    } exp_t;

    exp_t sb[$];

    controle_bandeja #(
        .TEMPO_VEDACAO (3),
        .CARGA_DEZENAS (2),
        .CARGA_UNIDADES(9)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .sensor_garrafa  (sensor_garrafa),
        .reabastecer     (reabastecer),
        .motor           (motor),
        .vedar           (vedar),
        .unidades_bandeja(unidades_bandeja),
        .dezenas_bandeja (dezenas_bandeja),
        .MC              (MC),
        .BZ              (BZ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step(input string tag, input logic s, input logic r,
                        input logic rst, input logic m, input logic v,
                        input logic bz);
        exp_t e;
        reset          = rst;
        sensor_garrafa = s;
        reabastecer    = r;
        e.tag   = tag;
        e.motor = m;
        e.vedar = v;
        e.bz    = bz;
        e.n     = n;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".motor"}, 8'(motor), 8'(e.motor));
        chk({e.tag, ".vedar"}, 8'(vedar), 8'(e.vedar));
        chk({e.tag, ".BZ"}, 8'(BZ), 8'(e.bz));
        chk({e.tag, ".uni"}, 8'(unidades_bandeja), 8'(e.n % 10));
        chk({e.tag, ".dez"}, 8'(dezenas_bandeja), 8'(e.n / 10));
        chk({e.tag, ".MC"}, 8'(MC), 8'(e.n > 0 && e.n < 10));
    endtask

    // one bottle from ESPERA; rab drives refill while it must be ignored
    task automatic bottle(input int hold, input logic rab);
        step("selar1", 1, 0, 0, 0, 1, 0);
        step("selar2", 1, rab, 0, 0, 1, 0);
        step("selar3", 1, rab, 0, 0, 1, 0);
        step("decr", 1, rab, 0, 0, 0, 0);
        n = n - 1;
        step("libera", 1, rab, 0, 1, 0, 0);
        repeat (hold) step("segura", 1, rab, 0, 1, 0, 0);
        if (n == 0) step("vazio", 0, 0, 0, 0, 0, 1);
        else step("espera", 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        #1;
        n = 29;
        step("reset", 0, 0, 1, 1, 0, 0);
        step("idle", 0, 0, 0, 1, 0, 0);

        bottle(5, 0);
        bottle(45, 0);
        bottle(2, 1);
        repeat (11) bottle(0, 0);

        n = 29;
        step("simult", 1, 1, 0, 1, 0, 0);
        bottle(0, 0);

        repeat (8) bottle(0, 0);
        bottle(0, 0);
        repeat (9) bottle(0, 0);
        bottle(0, 0);
        repeat (9) bottle(0, 0);

        repeat (4) step("vazio_ign", 1, 0, 0, 0, 0, 1);
        step("vazio_ign", 0, 0, 0, 0, 0, 1);
        n = 29;
        step("recarga", 0, 1, 0, 1, 0, 0);
        step("idle", 0, 0, 0, 1, 0, 0);

        n = 29;
        step("reset2", 0, 0, 1, 1, 0, 0);
        repeat (17) bottle(0, 0);
        step("selar1", 1, 0, 0, 0, 1, 0);
        n = 29;
        step("rst_mid", 1, 0, 1, 1, 0, 0);
        step("pos_rst", 0, 0, 0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
